// File: rtl/riscv_divider.sv
// 32-bit restoring radix-2 divider for RISC-V DIV/DIVU/REM/REMU (32 iterations, one per cycle).
// Define RISCV_DIV_EARLY_OUT_EN to finish divide-by-zero and signed-overflow requests without iterating.
module riscv_divider (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic        flush_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] result_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [4:0]  count;
    logic [31:0] quot_q;
    logic [31:0] rem_q;
    logic [31:0] divisor_q;
    logic [31:0] res_q;
    logic [31:0] last_q;
    logic [31:0] special_val_q;
    logic        is_rem_q;
    logic        neg_quot_q;
    logic        neg_rem_q;
    logic        special_q;

    logic        accept;
    logic        op_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        div_zero;
    logic        overflow;
    logic        special_in;
    logic [31:0] special_val_in;
    logic [32:0] r_shift;
    logic [32:0] diff;
    logic [31:0] rem_next;
    logic [31:0] quot_next;
    logic [31:0] final_val;

    assign ready_o  = (state != BUSY);
    assign accept   = valid_i && ready_o && !flush_i;
    // A flush in the DONE cycle swallows the pulse, so result_o only exposes res_q while valid_o is high.
    assign valid_o  = (state == DONE) && !flush_i;
    assign result_o = valid_o ? res_q : last_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        op_signed      = ~op_i[0];
        a_neg          = op_signed & opa_i[31];
        b_neg          = op_signed & opb_i[31];
        mag_a          = a_neg ? (~opa_i + 32'd1) : opa_i;
        mag_b          = b_neg ? (~opb_i + 32'd1) : opb_i;
        div_zero       = (opb_i == 32'd0);
        overflow       = op_signed && (opa_i == 32'h8000_0000) && (opb_i == 32'hFFFF_FFFF);
        special_in     = div_zero || overflow;
        special_val_in = 32'd0;
        if (div_zero) begin
            special_val_in = op_i[1] ? opa_i : 32'hFFFF_FFFF;
        end else if (overflow) begin
            special_val_in = op_i[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    always_comb begin
        r_shift   = {rem_q, quot_q[31]};
        diff      = r_shift - {1'b0, divisor_q};
        rem_next  = diff[32] ? r_shift[31:0] : diff[31:0];
        quot_next = {quot_q[30:0], ~diff[32]};
        final_val = quot_next;
        if (special_q) begin
            final_val = special_val_q;
        end else if (is_rem_q) begin
            final_val = neg_rem_q ? (~rem_next + 32'd1) : rem_next;
        end else if (neg_quot_q) begin
            final_val = ~quot_next + 32'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the working registers are plain flops, not a memory, so clearing them on reset is cheap and deterministic.
            state         <= IDLE;
            count         <= 5'd0;
            quot_q        <= 32'd0;
            rem_q         <= 32'd0;
            divisor_q     <= 32'd0;
            res_q         <= 32'd0;
            last_q        <= 32'd0;
            special_val_q <= 32'd0;
            is_rem_q      <= 1'b0;
            neg_quot_q    <= 1'b0;
            neg_rem_q     <= 1'b0;
            special_q     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (valid_o) begin
                        last_q <= res_q;
                    end
                    if (accept) begin
                        count         <= 5'd0;
                        quot_q        <= mag_a;
                        rem_q         <= 32'd0;
                        divisor_q     <= mag_b;
                        is_rem_q      <= op_i[1];
                        neg_quot_q    <= a_neg ^ b_neg;
                        neg_rem_q     <= a_neg;
                        special_q     <= special_in;
                        special_val_q <= special_val_in;
`ifdef RISCV_DIV_EARLY_OUT_EN
                        if (special_in) begin
                            res_q <= special_val_in;
                            state <= DONE;
                        end else begin
                            state <= BUSY;
                        end
`else
                        state <= BUSY;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        rem_q  <= rem_next;
                        quot_q <= quot_next;
                        count  <= count + 5'd1;
                        if (count == 5'd31) begin
                            res_q <= final_val;
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/riscv_divider.md
RISCV_DIVIDER -- requirements
Module: riscv_divider

Interface
REQ-001: The block SHALL have no parameters; width is fixed at 32 bits.
REQ-002: clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003: rst_i  input  1  SHALL be the reset, synchronous and active-high.
REQ-004: valid_i  input  1  SHALL mark a division request, qualified by ready_o.
REQ-005: op_i  input  2  SHALL select the operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006: opa_i  input  32  SHALL carry the dividend.
REQ-007: opb_i  input  32  SHALL carry the divisor.
REQ-008: flush_i  input  1  SHALL abort any request in flight.
REQ-009: ready_o  output  1  SHALL indicate that a request can be accepted this cycle.
REQ-010: valid_o  output  1  SHALL be a one-cycle pulse marking result_o as valid.
REQ-011: result_o  output  32  SHALL carry the quotient or remainder.

Function
REQ-012: States SHALL be IDLE, BUSY and DONE.
REQ-013: Acceptance SHALL occur on an edge where valid_i && ready_o && !flush_i; op_i, opa_i and opb_i are captured on that edge.
REQ-014: IDLE->BUSY SHALL occur on acceptance.
REQ-015: BUSY SHALL run 32 restoring radix-2 iterations, one per cycle, tracked by a 5-bit counter.
REQ-016: BUSY->DONE SHALL occur after iteration 32.
REQ-017: DONE SHALL last one cycle, then go to IDLE, or to BUSY if a new request is accepted in that cycle.
REQ-018: ready_o SHALL be high in IDLE and DONE and low in BUSY.
REQ-019: valid_o SHALL be high only in DONE, exactly 33 cycles after the accepting edge (full path).
REQ-020: result_o SHALL hold its value until the next valid_o.
REQ-021: Signed ops SHALL divide operand magnitudes.
REQ-022: The quotient SHALL be negated when the operand signs differ.
REQ-023: The remainder SHALL take the dividend's sign.
REQ-024: Divisor zero SHALL give DIV/DIVU = 0xFFFFFFFF and REM/REMU = dividend.
REQ-025: Signed overflow, opa=0x80000000 with opb=0xFFFFFFFF, SHALL give DIV = 0x80000000 and REM = 0.
REQ-026: valid_i while BUSY SHALL be ignored, with no queuing.
REQ-027: flush_i in BUSY or DONE SHALL force IDLE on the next edge and suppress valid_o; result_o is unchanged.
REQ-028: flush_i and valid_i together SHALL result in no acceptance.
REQ-029: Operand inputs SHALL be don't-care after acceptance.

Reset
REQ-030: rst_i high at an edge SHALL force IDLE, valid_o=0, ready_o=1, result_o=0x00000000, and clear the counter and working registers.
REQ-031: Reset during BUSY SHALL discard the operation, with no valid_o afterwards.
REQ-032: Reset SHALL override valid_i and flush_i.

Configuration
REQ-033: With macro RISCV_DIV_EARLY_OUT_EN defined, divide-by-zero and signed-overflow requests SHALL skip BUSY: accepting edge -> DONE, so valid_o is high 1 cycle after acceptance with the REQ-024/025 values.
REQ-034: Without RISCV_DIV_EARLY_OUT_EN, those cases SHALL take the full 33-cycle path and produce identical result values.
REQ-035: All other requests SHALL be unaffected by the macro.

Verification
REQ-036: DIVU opa=100 opb=7 -> valid_o pulse 33 cycles after acceptance with result_o=14; REMU with the same operands -> 2.
REQ-037: DIV opa=0xFFFFFFF9 (-7) opb=2 -> 0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFF (-1).
REQ-038: DIV opa=0x80000000 opb=0xFFFFFFFF -> 0x80000000; REMU opa=5 opb=0 -> 5; latency 1 cycle with RISCV_DIV_EARLY_OUT_EN, 33 cycles without.
REQ-039: Accept DIVU 1000/10, assert flush_i on cycle 10 -> no valid_o, ready_o=1 next cycle, result_o unchanged.
REQ-040: Back-to-back: valid_i held high with DIVU 9/3 then DIVU 20/4 -> second accepted in the DONE cycle of the first, results 3 then 5, 33 cycles apart.
REQ-041: rst_i pulsed at cycle 15 of BUSY -> valid_o stays 0, ready_o=1 and result_o=0 on the next cycle.
